// File: rtl/schoolbook_pkg.sv
// Shared definitions for the restoring shift-subtract divider.
package schoolbook_pkg;

    localparam int DEFAULT_W = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/schoolbook_div_step.sv
// One restoring-division iteration.
// The partial remainder with the next dividend bit appended is compared and subtracted at W+1 bits.
module schoolbook_div_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] rem,
    input  logic         bit_in,
    input  logic [W-1:0] d,
    output logic [W-1:0] rem_next,
    output logic         qbit
);

    logic [W:0]   w_t;
    logic [W-1:0] w_diff;

    assign w_t    = {rem, bit_in};
    assign qbit   = (w_t >= {1'b0, d});
    // rem < d on entry, so t - d < d and the low W bits hold the exact difference
    assign w_diff = w_t[W-1:0] - d;
    assign rem_next = qbit ? w_diff : w_t[W-1:0];

endmodule

// File: rtl/schoolbook_div.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Start/done handshake; err flags divide-by-zero or a quotient that does not fit in W bits.
module schoolbook_div
    import schoolbook_pkg::*;
#(
    parameter  int W  = DEFAULT_W,
    localparam int CW = $clog2(W + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-1:0] n,
    input  logic [W-1:0]   d,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [W-1:0]   q,
    output logic [W-1:0]   r
);

    state_t         r_state;
    state_t         w_state_next;
    logic [2*W-1:0] r_n;
    logic [W-1:0]   r_d;
    logic [W-1:0]   r_rem;
    logic [W-1:0]   r_sh;
    logic [CW-1:0]  r_count;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_r;
    logic           r_err;

    logic [W-1:0]   w_rem_next;
    logic           w_qbit;
    logic           w_bad;
    logic           w_last;

    schoolbook_div_step #(.W(W)) u_step (
        .rem      (r_rem),
        .bit_in   (r_sh[W-1]),
        .d        (r_d),
        .rem_next (w_rem_next),
        .qbit     (w_qbit)
    );

    // High half >= divisor also covers d == 0, but keep both terms explicit
    assign w_bad  = (r_d == '0) || (r_n[2*W-1:W] >= r_d);
    assign w_last = (r_count == CW'(W - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = CHECK;
            CHECK:   w_state_next = w_bad ? DONE : RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_n     <= '0;
            r_d     <= '0;
            r_rem   <= '0;
            r_sh    <= '0;
            r_count <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_n <= n;
                        r_d <= d;
                    end
                end
                CHECK: begin
                    if (w_bad) begin
                        r_q   <= {W{1'b1}};
                        r_r   <= r_n[W-1:0];
                        r_err <= 1'b1;
                    end else begin
                        r_rem   <= r_n[2*W-1:W];
                        r_sh    <= r_n[W-1:0];
                        r_count <= '0;
                        r_err   <= 1'b0;
                    end
                end
                RUN: begin
                    r_rem   <= w_rem_next;
                    r_sh    <= {r_sh[W-2:0], w_qbit};
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        r_q <= {r_sh[W-2:0], w_qbit};
                        r_r <= w_rem_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign err  = r_err;
    assign q    = r_q;
    assign r    = r_r;

endmodule

// File: tb/tb_schoolbook_div.sv
// Scoreboard bench for schoolbook_div at W=8 (directed, handshake, random) and W=256 (sample).
module tb_schoolbook_div;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       e;
    } exp8_t;

    typedef struct packed {
        logic [255:0] q;
        logic [255:0] r;
        logic         e;
    } exp256_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic         start8 = 1'b0;
    logic [15:0]  n8 = '0;
    logic [7:0]   d8 = '0;
    logic         busy8, done8, err8;
    logic [7:0]   q8, r8;

    logic         start256 = 1'b0;
    logic [511:0] n256 = '0;
    logic [255:0] d256 = '0;
    logic         busy256, done256, err256;
    logic [255:0] q256, r256;

    int errors = 0;
    int checks = 0;

    exp8_t   sb8[$];
    exp256_t sb256[$];

    always #5 clk = ~clk;

    schoolbook_div #(.W(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .n     (n8),
        .d     (d8),
        .busy  (busy8),
        .done  (done8),
        .err   (err8),
        .q     (q8),
        .r     (r8)
    );

    schoolbook_div #(.W(256)) dut256 (
        .clk   (clk),
        .rst   (rst),
        .start (start256),
        .n     (n256),
        .d     (d256),
        .busy  (busy256),
        .done  (done256),
        .err   (err256),
        .q     (q256),
        .r     (r256)
    );

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitors: pop one expectation per done pulse
    always @(negedge clk) begin
        if (done8) begin
            if (sb8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done8: got done with empty scoreboard, expected none");
            end else begin
                exp8_t e;
                e = sb8.pop_front();
                check("q8", 512'(q8), 512'(e.q));
                check("r8", 512'(r8), 512'(e.r));
                check("err8", 512'(err8), 512'(e.e));
                $display("done8: q=%02h r=%02h err=%0b (exp q=%02h r=%02h err=%0b)",
                         q8, r8, err8, e.q, e.r, e.e);
            end
        end
        if (done256) begin
            if (sb256.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done256: got done with empty scoreboard, expected none");
            end else begin
                exp256_t e;
                e = sb256.pop_front();
                check("q256", 512'(q256), 512'(e.q));
                check("r256", 512'(r256), 512'(e.r));
                check("err256", 512'(err256), 512'(e.e));
                $display("done256: q=%0h r=%0h err=%0b", q256, r256, err256);
            end
        end
    end

    // Issue one W=8 divide, check latency in edges; optionally pulse start at edge pulse_at
    task automatic run8(input logic [15:0] nn, input logic [7:0] dd,
                        input logic [7:0] eq, input logic [7:0] er, input logic ee,
                        input int lat, input int pulse_at);
        int edges;
        bit seen;
        sb8.push_back('{q: eq, r: er, e: ee});
        @(negedge clk);
        n8 = nn;
        d8 = dd;
        start8 = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        start8 = 1'b0;
        n8 = ~nn;
        d8 = ~dd;
        seen = 1'b0;
        while (edges < 40) begin
            @(negedge clk);
            if (done8) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            edges++;
            #1;
            start8 = (edges == pulse_at);
        end
        start8 = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout8: no done within %0d edges, expected done at edge %0d", edges, lat);
        end else begin
            check("latency8", 512'(edges), 512'(lat));
        end
    endtask

    function automatic exp8_t model8(input logic [15:0] nn, input logic [7:0] dd);
        exp8_t e;
        if (dd == 8'd0 || nn[15:8] >= dd) begin
            e.q = 8'hFF;
            e.r = nn[7:0];
            e.e = 1'b1;
        end else begin
            e.q = 8'(nn / 16'(dd));
            e.r = 8'(nn % 16'(dd));
            e.e = 1'b0;
        end
        return e;
    endfunction

    initial begin
        logic [511:0] big_d;
        logic [511:0] big_n;
        int edges;
        bit seen;

        // Reset state
        #1;
        check("rst_busy", 512'(busy8), 512'(0));
        check("rst_done", 512'(done8), 512'(0));
        check("rst_err", 512'(err8), 512'(0));
        check("rst_q", 512'(q8), 512'(0));
        check("rst_r", 512'(r8), 512'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Directed W=8 vectors
        run8(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 10, 0);
        run8(16'h00FF, 8'h00, 8'hFF, 8'hFF, 1'b1, 2, 0);
        run8(16'h5600, 8'h56, 8'hFF, 8'h00, 1'b1, 2, 0);
        run8(16'h55FF, 8'h56, 8'hFF, 8'h55, 1'b0, 10, 0);
        run8(16'h0007, 8'h01, 8'h07, 8'h00, 1'b0, 10, 0);
        run8(16'h00FE, 8'hFF, 8'h00, 8'hFE, 1'b0, 10, 0);
        run8(16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 10, 0);
        run8(16'h0100, 8'h01, 8'hFF, 8'h00, 1'b1, 2, 0);

        // start pulsed mid-RUN must be ignored (extra done would hit an empty scoreboard)
        run8(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 10, 5);

        // start held high: ignored in DONE, accepted on the following cycle
        sb8.push_back('{q: 8'h36, r: 8'h10, e: 1'b0});
        sb8.push_back('{q: 8'h36, r: 8'h10, e: 1'b0});
        @(negedge clk);
        n8 = 16'h1234;
        d8 = 8'h56;
        start8 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done8) begin
                seen = 1'b1;
                break;
            end
        end
        check("held_done_seen", 512'(seen), 512'(1));
        @(negedge clk);
        check("held_idle_gap", 512'(busy8), 512'(0));
        @(negedge clk);
        check("held_reaccept", 512'(busy8), 512'(1));
        start8 = 1'b0;
        for (int i = 0; i < 40 && !done8; i++) @(negedge clk);
        @(negedge clk);

        // Async reset mid-RUN clears everything without a clock edge
        @(negedge clk);
        n8 = 16'h1234;
        d8 = 8'h56;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("pre_rst_busy", 512'(busy8), 512'(1));
        rst = 1'b0;
        #1;
        check("midrst_busy", 512'(busy8), 512'(0));
        check("midrst_q", 512'(q8), 512'(0));
        check("midrst_r", 512'(r8), 512'(0));
        check("midrst_done", 512'(done8), 512'(0));
        @(negedge clk);
        rst = 1'b1;
        run8(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 10, 0);

        // Random W=8 regression against the reference model
        for (int i = 0; i < 300; i++) begin
            logic [15:0] rn;
            logic [7:0]  rd;
            exp8_t e;
            rn = 16'($urandom);
            rd = 8'($urandom_range(0, 255));
            e = model8(rn, rd);
            run8(rn, rd, e.q, e.r, e.e, e.e ? 2 : 10, 0);
        end

        // W=256 sample: (2^256-1)*(2^255+3)+7 / (2^255+3)
        big_d = (512'd1 << 255) + 512'd3;
        big_n = ((512'd1 << 256) - 512'd1) * big_d + 512'd7;
        sb256.push_back('{q: {256{1'b1}}, r: 256'd7, e: 1'b0});
        @(negedge clk);
        n256 = big_n;
        d256 = big_d[255:0];
        start256 = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        start256 = 1'b0;
        n256 = '0;
        d256 = '0;
        seen = 1'b0;
        while (edges < 400) begin
            @(negedge clk);
            if (done256) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            edges++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout256: no done within %0d edges, expected edge 258", edges);
        end else begin
            check("latency256", 512'(edges), 512'(258));
        end

        repeat (3) @(negedge clk);
        check("sb8_empty", 512'(sb8.size()), 512'(0));
        check("sb256_empty", 512'(sb256.size()), 512'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
